// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: controller states and the default
// retire PC that marks the end of a program run.
package boot_pkg;

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_HOLD  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } boot_state_e;

   localparam logic [19:0] END_PC_DEFAULT = 20'h000b0;
   localparam int unsigned COUNTER_WIDTH  = 32;

endpackage

// File: rtl/boot_loader_if.sv
// Program-load handshake and instruction-memory write port of the boot loader.
interface boot_loader_if #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDRESS_BITS = 20
);
   logic                    load_valid;
   logic [DATA_WIDTH-1:0]   load_data;
   logic                    load_last;
   logic                    load_ready;
   logic                    mem_we;
   logic [ADDRESS_BITS-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   modport master (
      output load_valid, load_data, load_last,
      input  load_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  load_valid, load_data, load_last,
      output load_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/boot_loader_sat_counter.sv
// Run-statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Increment request, held once the counter is full
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams a program image into instruction memory, releases the
// core from reset, then gathers run statistics until the end PC retires.
module boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned             DATA_WIDTH   = 32,
   parameter int unsigned             ADDRESS_BITS = 20,
   parameter logic [ADDRESS_BITS-1:0] END_PC       = ADDRESS_BITS'(END_PC_DEFAULT)
) (
   input  logic                     clock,
   input  logic                     reset,
   boot_loader_if.slave             bus,
   input  logic [ADDRESS_BITS-1:0]  boot_address,
   output logic                     core_reset,
   output logic                     core_start,
   output logic [ADDRESS_BITS-1:0]  core_prog_address,
   input  logic                     retire_valid,
   input  logic [ADDRESS_BITS-1:0]  retire_pc,
   input  logic                     core_stall,
   input  logic                     core_flush,
   output logic                     done,
   output logic [COUNTER_WIDTH-1:0] cycle_count,
   output logic [COUNTER_WIDTH-1:0] stall_count,
   output logic [COUNTER_WIDTH-1:0] flush_count,
   output logic [ADDRESS_BITS-1:0]  word_count
);
   boot_state_e             state_q, state_d;
   logic                    hold_cnt_q, hold_cnt_d;
   logic                    load_ready_q;
   logic                    mem_we_q;
   logic [ADDRESS_BITS-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic [ADDRESS_BITS-1:0] word_count_q;
   logic                    core_reset_q;
   logic                    core_start_q;
   logic                    done_q;
   logic [ADDRESS_BITS-1:0] prog_addr_q;
   logic                    accept_s;
   logic                    run_s;

   assign accept_s = bus.load_valid & load_ready_q;
   assign run_s    = (state_q == ST_RUN);

   // Next-state logic; HOLD spans two cycles using a one-bit sub-count
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_LOAD: begin
            hold_cnt_d = 1'b0;
            if (accept_s && bus.load_last) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_q) begin
               state_d = ST_START;
            end else begin
               hold_cnt_d = 1'b1;
            end
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            if (retire_valid && (retire_pc == END_PC)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_LOAD;
      endcase
   end

   // State, write port and core-control registers; outputs follow the next state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_LOAD;
         hold_cnt_q   <= 1'b0;
         load_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {ADDRESS_BITS{1'b0}};
         mem_wdata_q  <= {DATA_WIDTH{1'b0}};
         word_count_q <= {ADDRESS_BITS{1'b0}};
         core_reset_q <= 1'b1;
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         prog_addr_q  <= {ADDRESS_BITS{1'b0}};
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         load_ready_q <= (state_d == ST_LOAD);
         mem_we_q     <= accept_s;
         if (accept_s) begin
            mem_addr_q   <= boot_address + {word_count_q[ADDRESS_BITS-3:0], 2'b00};
            mem_wdata_q  <= bus.load_data;
            word_count_q <= word_count_q + ADDRESS_BITS'(1);
         end
         core_reset_q <= (state_d == ST_LOAD) || (state_d == ST_HOLD);
         core_start_q <= (state_d == ST_START);
         done_q       <= (state_d == ST_DONE);
         if ((state_q == ST_LOAD) && (state_d == ST_HOLD)) begin
            prog_addr_q <= boot_address;
         end
      end
   end

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cycle_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (run_s),
      .count_o (cycle_count)
   );

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (run_s & core_stall),
      .count_o (stall_count)
   );

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (run_s & core_flush),
      .count_o (flush_count)
   );

   assign bus.load_ready    = load_ready_q;
   assign bus.mem_we        = mem_we_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign core_reset        = core_reset_q;
   assign core_start        = core_start_q;
   assign core_prog_address = prog_addr_q;
   assign done              = done_q;
   assign word_count        = word_count_q;
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a phase-level reference model checked every cycle,
// plus literal expectations for the load, run and reset scenarios.
module tb_boot_loader;
   localparam int     P_LOAD = 0, P_HOLD = 1, P_START = 2, P_RUN = 3, P_DONE = 4;
   localparam longint ADDR_MOD = 64'd1048576;
   localparam longint CNT_MAX  = 64'hFFFF_FFFF;

   logic        clock = 1'b0;
   logic        reset;
   logic [19:0] boot_address;
   logic        core_reset, core_start, done;
   logic [19:0] core_prog_address, retire_pc, word_count;
   logic        retire_valid, core_stall, core_flush;
   logic [31:0] cycle_count, stall_count, flush_count;

   boot_loader_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) bus ();

   boot_loader dut (
      .clock             (clock),
      .reset             (reset),
      .bus               (bus),
      .boot_address      (boot_address),
      .core_reset        (core_reset),
      .core_start        (core_start),
      .core_prog_address (core_prog_address),
      .retire_valid      (retire_valid),
      .retire_pc         (retire_pc),
      .core_stall        (core_stall),
      .core_flush        (core_flush),
      .done              (done),
      .cycle_count       (cycle_count),
      .stall_count       (stall_count),
      .flush_count       (flush_count),
      .word_count        (word_count)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sat_inc(input longint v, input logic en);
      return (en && (v < CNT_MAX)) ? v + 1 : v;
   endfunction

   // Reference model: phases and counters from the block's behavioural rules
   int     m_phase, m_next, m_hold_left;
   bit     m_ready, m_we;
   longint m_addr, m_data, m_words, m_prog, m_cyc, m_stall, m_flush;
   wire    m_acc = (m_phase == P_LOAD) && m_ready && bus.load_valid;

   always_comb begin
      m_next = m_phase;
      case (m_phase)
         P_LOAD:  if (m_acc && bus.load_last) m_next = P_HOLD;
         P_HOLD:  if (m_hold_left == 1) m_next = P_START;
         P_START: m_next = P_RUN;
         P_RUN:   if (retire_valid && (retire_pc == 20'h000b0)) m_next = P_DONE;
         default: m_next = m_phase;
      endcase
   end

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_phase <= P_LOAD; m_ready <= 1'b0; m_we <= 1'b0; m_hold_left <= 2;
         m_addr <= 0; m_data <= 0; m_words <= 0; m_prog <= 0;
         m_cyc <= 0; m_stall <= 0; m_flush <= 0;
      end else begin
         m_phase <= m_next;
         m_ready <= (m_next == P_LOAD);
         m_we    <= m_acc;
         if (m_acc) begin
            m_addr  <= (longint'(boot_address) + 4 * m_words) % ADDR_MOD;
            m_data  <= longint'(bus.load_data);
            m_words <= (m_words + 1) % ADDR_MOD;
         end
         m_hold_left <= (m_phase == P_HOLD) ? m_hold_left - 1 : 2;
         if ((m_phase == P_LOAD) && (m_next == P_HOLD)) m_prog <= longint'(boot_address);
         if (m_phase == P_RUN) begin
            m_cyc   <= sat_inc(m_cyc, 1'b1);
            m_stall <= sat_inc(m_stall, core_stall);
            m_flush <= sat_inc(m_flush, core_flush);
         end
      end
   end

   // Per-cycle comparison against the model, plus write/phase logs
   logic [19:0] addr_log[$];
   logic [31:0] data_log[$];
   int          hold_seen = 0;
   int          start_seen = 0;
   logic [19:0] start_prog = 20'h0;

   always @(negedge clock) begin
      check("load_ready", bus.load_ready, m_ready);
      check("mem_we", bus.mem_we, m_we);
      if (m_we) begin
         check("mem_addr", bus.mem_addr, m_addr);
         check("mem_wdata", bus.mem_wdata, m_data);
      end
      check("word_count", word_count, m_words);
      check("core_reset", core_reset, (m_phase == P_LOAD) || (m_phase == P_HOLD));
      check("core_start", core_start, m_phase == P_START);
      check("done", done, m_phase == P_DONE);
      check("core_prog_address", core_prog_address, m_prog);
      check("cycle_count", cycle_count, m_cyc);
      check("stall_count", stall_count, m_stall);
      check("flush_count", flush_count, m_flush);
      if (bus.mem_we === 1'b1) begin
         addr_log.push_back(bus.mem_addr);
         data_log.push_back(bus.mem_wdata);
      end
      if (reset && core_reset && !bus.load_ready) hold_seen++;
      if (core_start === 1'b1) begin
         start_seen++;
         start_prog = core_prog_address;
      end
   end

   task automatic send_word(input logic [31:0] d, input logic last);
      bit got = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      bus.load_last  = last;
      for (int n = 0; n < 20 && !got; n++) begin
         got = bus.load_ready;
         @(negedge clock);
      end
      check("accept_timeout", got, 1'b1);
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
   endtask

   task automatic idle_cycle();
      bus.load_data = 32'hDEAD_BEEF;
      @(negedge clock);
   endtask

   task automatic wait_start();
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clock);
         seen = core_start;
      end
      check("start_timeout", seen, 1'b1);
   endtask

   initial begin
      reset = 1'b0; boot_address = 20'h0;
      bus.load_valid = 1'b0; bus.load_data = 32'h0; bus.load_last = 1'b0;
      retire_valid = 1'b0; retire_pc = 20'h0; core_stall = 1'b0; core_flush = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_core_reset", core_reset, 1'b1);
      check("rst_load_ready", bus.load_ready, 1'b0);
      #2 reset = 1'b1;
      @(negedge clock);

      // Four-word image at base 0, then a 20-cycle run
      send_word(32'h1111_0001, 1'b0);
      send_word(32'h2222_0002, 1'b0);
      send_word(32'h3333_0003, 1'b0);
      send_word(32'h4444_0004, 1'b1);
      wait_start();
      @(negedge clock);
      for (int i = 1; i <= 20; i++) begin
         core_stall   = (i == 2) || (i == 5) || (i == 9) || (i == 12);
         core_flush   = (i == 3) || (i == 7) || (i == 12);
         retire_valid = (i == 15) || (i == 20);
         retire_pc    = (i == 10 || i == 20) ? 20'h000b0 : ((i == 15) ? 20'h000ac : 20'h0);
         @(negedge clock);
      end
      retire_valid = 1'b0; retire_pc = 20'h0; core_flush = 1'b0;
      core_stall = 1'b1;
      bus.load_valid = 1'b1;
      repeat (3) @(negedge clock);
      core_stall = 1'b0; bus.load_valid = 1'b0;
      check("a_nwrites", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         check("a_addr0", addr_log[0], 20'h00000);
         check("a_addr1", addr_log[1], 20'h00004);
         check("a_addr2", addr_log[2], 20'h00008);
         check("a_addr3", addr_log[3], 20'h0000C);
         check("a_data3", data_log[3], 32'h4444_0004);
      end
      check("a_hold_cycles", hold_seen, 2);
      check("a_start_pulses", start_seen, 1);
      check("a_start_prog", start_prog, 20'h00000);
      check("a_done", done, 1'b1);
      check("a_cycles", cycle_count, 32'd20);
      check("a_stalls", stall_count, 32'd4);
      check("a_flushes", flush_count, 32'd3);
      check("a_words", word_count, 20'd4);

      // Reset in the middle of a load, with toggled valid
      #2 reset = 1'b0;
      boot_address = 20'h00100;
      @(negedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      send_word(32'hAAAA_0000, 1'b0);
      idle_cycle();
      send_word(32'hAAAA_0001, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("b_we_at_reset", bus.mem_we, 1'b0);
      check("b_words_at_reset", word_count, 20'd0);
      @(negedge clock);
      boot_address = 20'hFFFFC;
      #2 reset = 1'b1;
      addr_log.delete(); data_log.delete();
      start_seen = 0;
      @(negedge clock);

      // Reload at the top of the address space with gaps between words
      send_word(32'hC0DE_0000, 1'b0);
      idle_cycle();
      send_word(32'hC0DE_0001, 1'b0);
      idle_cycle();
      send_word(32'hC0DE_0002, 1'b1);
      wait_start();
      @(negedge clock);
      retire_valid = 1'b1; retire_pc = 20'h000b0;
      @(negedge clock);
      retire_valid = 1'b0; retire_pc = 20'h0;
      @(negedge clock);
      check("b_nwrites", addr_log.size(), 3);
      if (addr_log.size() == 3) begin
         check("b_addr0", addr_log[0], 20'hFFFFC);
         check("b_addr1", addr_log[1], 20'h00000);
         check("b_addr2", addr_log[2], 20'h00004);
         check("b_data1", data_log[1], 32'hC0DE_0001);
      end
      check("b_words", word_count, 20'd3);
      check("b_start_prog", start_prog, 20'hFFFFC);
      check("b_done", done, 1'b1);
      check("b_cycles", cycle_count, 32'd1);

      // Reset out of DONE clears everything at once
      #2 reset = 1'b0;
      #1;
      check("c_done", done, 1'b0);
      check("c_cycles", cycle_count, 32'd0);
      check("c_core_reset", core_reset, 1'b1);
      check("c_prog", core_prog_address, 20'h0);
      repeat (2) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Param DATA_WIDTH, default 32, instruction word width.
REQ-002 Param ADDRESS_BITS, default 20, byte-address width.
REQ-003 Param END_PC, default 20'h000b0, retire PC that ends a run.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low block reset.
REQ-006 load_valid  in  1  program word offered.
REQ-007 load_data  in  DATA_WIDTH  program word.
REQ-008 load_last  in  1  final word of the image.
REQ-009 load_ready  out  1  loader accepts a word this cycle.
REQ-010 boot_address  in  ADDRESS_BITS  image base and core start PC.
REQ-011 mem_we  out  1  instruction-memory write strobe.
REQ-012 mem_addr  out  ADDRESS_BITS  byte address of write.
REQ-013 mem_wdata  out  DATA_WIDTH  write data.
REQ-014 core_reset  out  1  active-high reset to core.
REQ-015 core_start  out  1  one-cycle start pulse to core.
REQ-016 core_prog_address  out  ADDRESS_BITS  start PC to core.
REQ-017 retire_valid  in  1  memwb stage holds a real instruction.
REQ-018 retire_pc  in  ADDRESS_BITS  PC of memwb instruction.
REQ-019 core_stall, core_flush  in  1 each  core hazard indications.
REQ-020 done  out  1  run finished.
REQ-021 cycle_count, stall_count, flush_count  out  32 each  run statistics.
REQ-022 word_count  out  ADDRESS_BITS  words loaded.

Function
REQ-023 FSM states LOAD, HOLD, START, RUN, DONE; HOLD lasts exactly 2 cycles, START exactly 1 cycle.
REQ-024 LOAD: load_ready=1; accept = load_valid & load_ready.
REQ-025 Each accept registers mem_we=1, mem_wdata=load_data, mem_addr=boot_address+4*word_count (mod 2^ADDRESS_BITS) on the next cycle, then increments word_count; 1-cycle write latency.
REQ-026 An accept with load_last=1 transitions LOAD->HOLD; the last write still issues.
REQ-027 Outside LOAD: load_ready=0, load_valid ignored, mem_we=0.
REQ-028 core_reset=1 in LOAD and HOLD, 0 in START, RUN, DONE.
REQ-029 START: core_start=1; HOLD->START->RUN unconditional.
REQ-030 core_prog_address = boot_address, registered on LOAD->HOLD, stable afterward.
REQ-031 RUN: cycle_count +1 every cycle; stall_count +1 when core_stall; flush_count +1 when core_flush; stall and flush in the same cycle both count.
REQ-032 All counters saturate at all-ones; word_count wraps.
REQ-033 RUN->DONE on the cycle retire_valid=1 and retire_pc==END_PC; that cycle is counted.
REQ-034 DONE: done=1, counters frozen, state held until reset.
REQ-035 retire_pc==END_PC with retire_valid=0 does not end the run.

Reset
REQ-036 reset low asynchronously forces state LOAD, all counters 0, mem_we 0, core_start 0, done 0, core_reset 1, core_prog_address 0.
REQ-037 load_ready becomes 1 on the first clock edge after reset deasserts.
REQ-038 Reset in any state, including mid-load or mid-run, abandons the operation with no partial write emitted after reset assertion.

Structure
REQ-039 FSM state encoding and default END_PC live in a shared package (boot_pkg).
REQ-040 The three saturating 32-bit counters use one sub-module, sat_counter, instantiated three times.

Verification
REQ-041 Load 4 words, base 0x00000, last on word 4 -> writes at 0x0,0x4,0x8,0xC, then core_reset high 2 cycles, core_start pulse with core_prog_address 0x00000.
REQ-042 load_valid toggled every other cycle -> only accepted words are written, and word_count equals the number of accepts.
REQ-043 RUN for 20 cycles with stall on 3 cycles, flush on 2, and 1 overlapping, then retire 0x000b0 -> done=1; cycle=20; stall=4; flush=3.
REQ-044 retire_pc=0x000b0 with retire_valid=0 -> no done; counting continues.
REQ-045 Base 0xFFFFC, 2 words -> addresses 0xFFFFC, 0x00000 (wrap).
REQ-046 Reset asserted mid-load after 2 words -> mem_we 0 immediately, word_count 0; reload proceeds normally.
